// File: rtl/serial_divisibility_by_n_using_fsm_if.sv
// Serial divisibility checker bus: bit-stream controls in, remainder/length status out.
interface serial_divisibility_by_n_using_fsm_if #(
  parameter int unsigned REM_W   = 3,
  parameter int unsigned COUNT_W = 8
);
  logic               start;
  logic               lsb_first;
  logic               bit_valid;
  logic               new_bit;
  logic               div_by_n;
  logic [REM_W-1:0]   remainder;
  logic [COUNT_W-1:0] bit_count;
  logic               lsb_mode;

  // Producer of the bit stream
  modport master (
    output start, lsb_first, bit_valid, new_bit,
    input  div_by_n, remainder, bit_count, lsb_mode
  );

  // Remainder tracker
  modport slave (
    input  start, lsb_first, bit_valid, new_bit,
    output div_by_n, remainder, bit_count, lsb_mode
  );
endinterface

// File: rtl/serial_divisibility_by_n_using_fsm.sv
// Serial remainder tracker: one bit per accepted cycle, reports value mod DIVISOR,
// divisibility, accepted-bit count and bit order.
// Optional feature macro: SERIAL_DIV_LSB_FIRST_EN builds the LSB-first datapath
// (power-of-two register); without it the block is MSB-first only.
module serial_divisibility_by_n_using_fsm #(
  parameter int unsigned DIVISOR = 5,
  parameter int unsigned COUNT_W = 8
) (
  input logic clk,
  input logic rst,
  serial_divisibility_by_n_using_fsm_if.slave bus
);

  localparam int unsigned REM_W = $clog2(DIVISOR);
  localparam int unsigned SUM_W = REM_W + 1;
  localparam logic [SUM_W-1:0]   N_SUM     = SUM_W'(DIVISOR);
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;
  localparam logic [REM_W-1:0]   POW_ONE   = REM_W'(1);

  // Every intermediate is below 2N, so one conditional subtract reduces it
  function automatic logic [REM_W-1:0] mod_reduce(input logic [SUM_W-1:0] s);
    return (s >= N_SUM) ? REM_W'(s - N_SUM) : REM_W'(s);
  endfunction

  logic [REM_W-1:0]   rem_q, rem_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               div_q, div_d;
  logic               mode_q;

  // Start-adjusted view of the state that the incoming bit is applied to
  logic [REM_W-1:0]   base_rem;
  logic [COUNT_W-1:0] base_count;
  logic               base_mode;

`ifdef SERIAL_DIV_LSB_FIRST_EN
  logic [REM_W-1:0] pow_q, pow_d, base_pow;
  logic             mode_d;

  // State register (LSB-first extras)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pow_q  <= POW_ONE;
      mode_q <= 1'b0;
    end else begin
      pow_q  <= pow_d;
      mode_q <= mode_d;
    end
  end
`else
  logic lsb_first_unused;

  assign mode_q           = 1'b0;
  assign lsb_first_unused = bus.lsb_first;
`endif

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q   <= '0;
      count_q <= '0;
      div_q   <= 1'b1;
    end else begin
      rem_q   <= rem_d;
      count_q <= count_d;
      div_q   <= div_d;
    end
  end

  // Next state: optional clear on start, then apply the accepted bit in the latched order
  always_comb begin
    base_rem   = rem_q;
    base_count = count_q;
    base_mode  = mode_q;
`ifdef SERIAL_DIV_LSB_FIRST_EN
    base_pow   = pow_q;
`endif
    if (bus.start) begin
      base_rem   = '0;
      base_count = '0;
`ifdef SERIAL_DIV_LSB_FIRST_EN
      base_pow   = POW_ONE;
      base_mode  = bus.lsb_first;
`else
      base_mode  = 1'b0;
`endif
    end

    rem_d   = base_rem;
    count_d = base_count;
`ifdef SERIAL_DIV_LSB_FIRST_EN
    pow_d   = base_pow;
    mode_d  = base_mode;
`endif

    if (bus.bit_valid) begin
      count_d = (base_count == COUNT_MAX) ? base_count : base_count + COUNT_W'(1);
`ifdef SERIAL_DIV_LSB_FIRST_EN
      if (base_mode) begin
        rem_d = mod_reduce({1'b0, base_rem} + (bus.new_bit ? {1'b0, base_pow} : '0));
        pow_d = mod_reduce({base_pow, 1'b0});
      end else begin
        rem_d = mod_reduce({base_rem, bus.new_bit});
      end
`else
      rem_d = mod_reduce({base_rem, bus.new_bit});
`endif
    end

    div_d = (rem_d == '0);
  end

  // Outputs are straight register reads
  always_comb begin
    bus.remainder = rem_q;
    bus.bit_count = count_q;
    bus.div_by_n  = div_q;
    bus.lsb_mode  = mode_q;
  end

endmodule

// File: tb/tb_serial_divisibility_by_n_using_fsm.sv
// Bench: four trackers (N=5, N=3, N=7, N=5 with 4-bit counter) share one bit stream
// and are compared against an arithmetic model of the number received so far.
module tb_serial_divisibility_by_n_using_fsm;

  localparam int NI = 4;
`ifdef SERIAL_DIV_LSB_FIRST_EN
  localparam bit LSB_EN = 1'b1;
`else
  localparam bit LSB_EN = 1'b0;
`endif

  function automatic int unsigned n_of(input int i);
    case (i)
      0: return 5;
      1: return 3;
      2: return 7;
      default: return 5;
    endcase
  endfunction

  function automatic int unsigned cw_of(input int i);
    return (i == 3) ? 4 : 8;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, lsb_first = 1'b0, bit_valid = 1'b0, new_bit = 1'b0;
  // {lsb_mode, bit_count[7:0], div_by_n, remainder[7:0]}
  logic [17:0] obs [NI];

  int checks = 0;
  int errors = 0;

  // Model: remainder of the number received so far, true (unsaturated) length, order
  int unsigned mrem [NI];
  int unsigned mlen [NI];
  bit          mmode [NI];

  localparam logic [17:0] RESET_WORD = {1'b0, 8'd0, 1'b1, 8'd0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned N  = n_of(g);
    localparam int unsigned CW = cw_of(g);
    localparam int unsigned RW = $clog2(N);

    serial_divisibility_by_n_using_fsm_if #(.REM_W(RW), .COUNT_W(CW)) bus ();

    assign bus.start     = start;
    assign bus.lsb_first = lsb_first;
    assign bus.bit_valid = bit_valid;
    assign bus.new_bit   = new_bit;
    assign obs[g] = {bus.lsb_mode, 8'(bus.bit_count), bus.div_by_n, 8'(bus.remainder)};

    serial_divisibility_by_n_using_fsm #(.DIVISOR(N), .COUNT_W(CW)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  function automatic int unsigned pow2mod(input int unsigned k, input int unsigned n);
    int unsigned p = 1 % n;
    for (int unsigned j = 0; j < k; j++) p = (2 * p) % n;
    return p;
  endfunction

  function automatic logic [17:0] exp_word(input int i);
    int unsigned mx  = (1 << cw_of(i)) - 1;
    int unsigned cnt = (mlen[i] > mx) ? mx : mlen[i];
    return {mmode[i], 8'(cnt), (mrem[i] == 0), 8'(mrem[i])};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NI; i++) begin
      mrem[i] = 0; mlen[i] = 0; mmode[i] = 1'b0;
    end
  endfunction

  // Apply one clock of stimulus and advance the model; outputs sampled 1ns after the edge
  task automatic step(input bit st, input bit lf, input bit bv, input bit nb);
    start = st; lsb_first = lf; bit_valid = bv; new_bit = nb;
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      if (st) begin
        mrem[i] = 0; mlen[i] = 0; mmode[i] = LSB_EN ? lf : 1'b0;
      end
      if (bv) begin
        if (mmode[i]) mrem[i] = (mrem[i] + (nb ? pow2mod(mlen[i], n_of(i)) : 0)) % n_of(i);
        else          mrem[i] = (2 * mrem[i] + 32'(nb)) % n_of(i);
        mlen[i]++;
      end
    end
    start = 1'b0; bit_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (obs[i] !== RESET_WORD) begin
        errors++; $display("FAIL reset dut%0d got %h expected %h", i, obs[i], RESET_WORD);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_msb_vector();
    bit          bits [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    int unsigned rems [4] = '{1, 2, 0, 0};
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (obs[i] !== exp_word(i)) begin
        errors++; $display("FAIL msb_start dut%0d got %h expected %h", i, obs[i], exp_word(i));
      end
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b1, bits[k]);
      checks++;
      if (obs[0][7:0] !== 8'(rems[k]) || obs[0][8] !== (rems[k] == 0) || obs[0][16:9] !== 8'(k + 1)) begin
        errors++; $display("FAIL msb_vector bit%0d got %h expected rem %0d count %0d", k, obs[0], rems[k], k + 1);
      end
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (obs[i] !== exp_word(i)) begin
          errors++; $display("FAIL msb_model dut%0d got %h expected %h", i, obs[i], exp_word(i));
        end
      end
    end
  endtask

  task automatic test_lsb_vector();
    bit          bits [3] = '{1'b0, 1'b1, 1'b1};
    int unsigned rl   [3] = '{0, 2, 0};
    int unsigned rm   [3] = '{0, 1, 0};
    step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'b1, bits[k]);
      checks++;
      if (obs[1][7:0] !== 8'(LSB_EN ? rl[k] : rm[k]) || obs[1][17] !== LSB_EN) begin
        errors++; $display("FAIL lsb_vector bit%0d got %h expected rem %0d mode %0d",
                           k, obs[1], LSB_EN ? rl[k] : rm[k], LSB_EN);
      end
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (obs[i] !== exp_word(i)) begin
          errors++; $display("FAIL lsb_model dut%0d got %h expected %h", i, obs[i], exp_word(i));
        end
      end
    end
  endtask

  task automatic test_bubbles();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      // lsb_first toggling without start must be ignored
      step(1'b0, k[0], (k % 3) == 0, 1'b1);
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (obs[i] !== exp_word(i)) begin
          errors++; $display("FAIL bubbles dut%0d cyc%0d got %h expected %h", i, k, obs[i], exp_word(i));
        end
      end
    end
    checks++;
    if (obs[2] !== {1'b0, 8'd3, 1'b1, 8'd0}) begin
      errors++; $display("FAIL bubbles_final got %h expected rem 0 count 3", obs[2]);
    end
  endtask

  task automatic test_start_with_bit();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (obs[0][7:0] !== 8'd3) begin
      errors++; $display("FAIL pre_restart got %h expected rem 3", obs[0]);
    end
    step(1'b1, 1'b0, 1'b1, 1'b1);
    checks++;
    if (obs[0] !== {1'b0, 8'd1, 1'b0, 8'd1}) begin
      errors++; $display("FAIL restart_with_bit got %h expected rem 1 count 1", obs[0]);
    end
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'($urandom), 1'b1, 1'($urandom));
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (obs[i] !== exp_word(i)) begin
          errors++; $display("FAIL restart_model dut%0d got %h expected %h", i, obs[i], exp_word(i));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    checks++;
    if (obs[0][7:0] !== 8'd3) begin
      errors++; $display("FAIL pre_reset got %h expected rem 3", obs[0]);
    end
    #2 rst = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (obs[i] !== RESET_WORD) begin
        errors++; $display("FAIL async_reset dut%0d got %h expected %h", i, obs[i], RESET_WORD);
      end
    end
    @(posedge clk);
    #1 rst = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (obs[i] !== exp_word(i)) begin
        errors++; $display("FAIL post_reset dut%0d got %h expected %h", i, obs[i], exp_word(i));
      end
    end
  endtask

  task automatic test_saturation();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obs[3] !== {1'b0, 8'd15, 1'b1, 8'd0}) begin
      errors++; $display("FAIL saturation got %h expected count 15 rem 0 div 1", obs[3]);
    end
    checks++;
    if (obs[0][16:9] !== 8'd20) begin
      errors++; $display("FAIL wide_count got %0d expected 20", obs[0][16:9]);
    end
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 1'b0, 1'b1, 1'($urandom));
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (obs[i] !== exp_word(i)) begin
          errors++; $display("FAIL saturated_track dut%0d got %h expected %h", i, obs[i], exp_word(i));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      step(($urandom % 20) == 0, 1'($urandom), ($urandom % 4) != 0, 1'($urandom));
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (obs[i] !== exp_word(i)) begin
          errors++; $display("FAIL random dut%0d cyc%0d got %h expected %h", i, k, obs[i], exp_word(i));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 400; k++) begin
      step(($urandom % 25) == 0, 1'($urandom), 1'b1, 1'($urandom));
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (obs[i] !== exp_word(i)) begin
          errors++; $display("FAIL back_to_back dut%0d cyc%0d got %h expected %h", i, k, obs[i], exp_word(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_msb_vector();
    test_lsb_vector();
    test_bubbles();
    test_start_with_bit();
    test_async_reset();
    test_saturation();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_divisibility_by_n_using_fsm.md
# serial_divisibility_by_n_using_fsm

Serial remainder tracker for an arbitrary compile-time divisor: consumes one bit of an unbounded binary number per accepted cycle and reports whether the number received so far is divisible by `DIVISOR`. It generalises the fixed divide-by-3/5 serial checkers with four additions:

- a `bit_valid` qualifier;
- a `start` input that begins a new number;
- a received-bit counter;
- an optional LSB-first mode.

It sits in the serial-arithmetic FSM family and feeds stream checkers that need remainder and length information.

## Interface
- `DIVISOR`, 5, divisor N; legal range 2..255.
- `REM_W`, `$clog2(DIVISOR)`, width of remainder/power registers; derived, not overridden.
- `COUNT_W`, 8, width of saturating received-bit counter.

Ports:
- `clk`  input  1  single clock, rising edge.
- `rst`  input  1  reset, asynchronous, active-low (asserted at 0).
- `start`  input  1  begin a new number this cycle.
- `lsb_first`  input  1  bit order for the new number; sampled only when `start`=1.
- `bit_valid`  input  1  `new_bit` is consumed on this edge.
- `new_bit`  input  1  next bit of the number.
- `div_by_n`  output  1  1 when current remainder == 0.
- `remainder`  output  REM_W  current value mod N.
- `bit_count`  output  COUNT_W  bits accepted since last start/reset; saturates at all-ones.
- `lsb_mode`  output  1  latched bit-order mode of the current number.

## Operation
- State registers:
  - `rem` (0..N-1).
  - `pow` (2^k mod N, LSB mode only).
  - `count`.
  - `mode`.
- All outputs are direct register reads. `div_by_n` = (`rem` == 0).
- MSB-first accept: `rem` ← (2·`rem` + `new_bit`) mod N.
- LSB-first accept:
  - `rem` ← (`rem` + (`new_bit` ? `pow` : 0)) mod N.
  - `pow` ← (2·`pow`) mod N.
- Each intermediate sum is < 2N. Reduce with one compare and conditional subtract of N; no divider. Intermediates are REM_W+1 bits wide.
- `count` increments on each accept and holds at 2^COUNT_W−1.
- `bit_valid`=0 and `start`=0: all state holds.
- `start`=1, `bit_valid`=0:
  - `rem` ← 0, `pow` ← 1, `count` ← 0, `mode` ← `lsb_first`.
- `start`=1, `bit_valid`=1: clear, then apply the bit in the new mode in the same edge. Result is `rem` = `new_bit`, `count` = 1, plus:
  - MSB mode: `pow` ← 1.
  - LSB mode: `pow` ← 2 mod N.
- `lsb_first` changes while `start`=0 are ignored.
- The empty number (after reset/start with no bits) reports divisible: `div_by_n`=1.
- Power-of-two N in LSB mode: `pow` reaches 0 and stays 0. This is the correct behaviour; higher bits no longer affect `rem`.

## Timing
- Reset (`rst`=0, asynchronous, any cycle including mid-number):
  - `rem`=0, `pow`=1, `count`=0, `mode`=0.
  - Outputs: `div_by_n`=1, `remainder`=0, `bit_count`=0, `lsb_mode`=0.
- Reset release is synchronous to `clk`. The first edge with `rst`=1 may accept a bit.
- Latency: 1 cycle. A bit accepted at edge k is reflected on all outputs immediately after edge k.
- No backpressure. A bit is accepted every cycle `bit_valid`=1; full rate, no gaps required.
- Counter saturation does not affect remainder tracking.

## Configuration
- `SERIAL_DIV_LSB_FIRST_EN` defined:
  - LSB-first datapath and `pow` register are built.
  - `lsb_first` is honoured at `start`.
- Not defined:
  - `pow` and LSB logic are removed.
  - `lsb_first` is ignored and `mode` is tied to 0.
  - `lsb_mode` is constant 0.
  - Block is MSB-first only.

## Test plan
- N=5, MSB: start, then bits 1,0,1,0 (=10) → `remainder` 1,2,0,0; `div_by_n` 0,0,1,1; `bit_count` 1..4.
- N=3, LSB (macro defined): start with `lsb_first`=1, bits 0,1,1 (6) → `remainder` 0,2,0; `div_by_n`=1 after bit 3; `lsb_mode`=1.
- N=7, MSB: bits 1,1,1 interleaved with `bit_valid`=0 bubbles → outputs hold during bubbles; final `remainder`=0, `bit_count`=3.
- N=5: after 1,1 (`rem`=3), assert `start`+`bit_valid` with `new_bit`=1 → `remainder`=1, `bit_count`=1 on that edge.
- Drive `rst`=0 between clock edges mid-number (`rem`=3) → outputs zero/`div_by_n`=1 immediately, without waiting for an edge.
- `COUNT_W`=4: 20 accepted zeros → `bit_count` saturates at 15; `div_by_n` stays 1; `remainder` stays 0.
